// File: rtl/bc_datapath_gen_if.sv
// Control-unit <-> datapath bundle for bc_datapath_gen: control inputs, the character I/O
// handshake and the architectural register view. clk/rst stay outside the bundle.
interface bc_datapath_gen_if #(
  parameter int DW  = 16,
  parameter int AW  = 12,
  parameter int SCW = 4
);
  logic [2:0]     bus_sel;
  logic [23:0]    ctrl;
  logic [2:0]     alu_op;
  logic [DW-1:0]  ext_word;

  // Handshakes: a transfer happens on a rising edge where valid && ready are both 1.
  // in_valid/in_data come from the producer, in_ready (= ~FGI) from the datapath.
  // out_valid (= ~FGO)/out_data come from the datapath, out_ready from the consumer.
  // A valid side never waits on ready before asserting.
  logic           in_valid;
  logic [7:0]     in_data;
  logic           in_ready;
  logic           out_valid;
  logic [7:0]     out_data;
  logic           out_ready;

  logic [AW-1:0]  pc;
  logic [AW-1:0]  ar;
  logic [DW-1:0]  ir;
  logic [DW-1:0]  ac;
  logic [DW-1:0]  dr;
  logic [DW-1:0]  tr;
  logic           e;
  logic [SCW-1:0] sc;
  logic           fgi;
  logic           fgo;
  logic           ac_zero;

  modport master (
    output bus_sel, ctrl, alu_op, ext_word, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, pc, ar, ir, ac, dr, tr, e, sc, fgi, fgo, ac_zero
  );

  modport slave (
    input  bus_sel, ctrl, alu_op, ext_word, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, pc, ar, ir, ac, dr, tr, e, sc, fgi, fgo, ac_zero
  );
endinterface

// File: rtl/bc_datapath_gen.sv
// Basic Computer datapath: registers, 8-source common bus, word memory, ALU + E, SC.
// Define BC_IO_EN to build the INPR/OUTR character port with FGI/FGO flags.
module bc_datapath_gen #(
  parameter int DW  = 16,
  parameter int AW  = 12,
  parameter int SCW = 4
) (
  input logic            clk,
  input logic            rst,
  bc_datapath_gen_if.slave dp
);

  localparam logic [2:0] ALU_AND  = 3'd0;
  localparam logic [2:0] ALU_ADD  = 3'd1;
  localparam logic [2:0] ALU_LDA  = 3'd2;
  localparam logic [2:0] ALU_CMA  = 3'd3;
  localparam logic [2:0] ALU_CIR  = 3'd4;
  localparam logic [2:0] ALU_CIL  = 3'd5;
  localparam logic [2:0] ALU_INP  = 3'd6;

  logic ld_ar, inr_ar, clr_ar, ld_pc, inr_pc, clr_pc;
  logic ld_dr, inr_dr, clr_dr, ld_ac, inr_ac, clr_ac;
  logic ld_ir, ld_tr, inr_tr, clr_tr, mem_we, clr_e, cme;
  logic ld_outr, inp_ack, sc_clr;

  assign ld_ar   = dp.ctrl[0];
  assign inr_ar  = dp.ctrl[1];
  assign clr_ar  = dp.ctrl[2];
  assign ld_pc   = dp.ctrl[3];
  assign inr_pc  = dp.ctrl[4];
  assign clr_pc  = dp.ctrl[5];
  assign ld_dr   = dp.ctrl[6];
  assign inr_dr  = dp.ctrl[7];
  assign clr_dr  = dp.ctrl[8];
  assign ld_ac   = dp.ctrl[9];
  assign inr_ac  = dp.ctrl[10];
  assign clr_ac  = dp.ctrl[11];
  assign ld_ir   = dp.ctrl[12];
  assign ld_tr   = dp.ctrl[13];
  assign inr_tr  = dp.ctrl[14];
  assign clr_tr  = dp.ctrl[15];
  assign mem_we  = dp.ctrl[16];
  assign clr_e   = dp.ctrl[17];
  assign cme     = dp.ctrl[18];
  assign ld_outr = dp.ctrl[19];
  assign inp_ack = dp.ctrl[20];
  assign sc_clr  = dp.ctrl[21];

  logic [AW-1:0]  ar_q, pc_q;
  logic [DW-1:0]  dr_q, ac_q, ir_q, tr_q;
  logic           e_q;
  logic [SCW-1:0] sc_q;
  logic [DW-1:0]  mem [2**AW];

  logic [DW-1:0]  bus_w;
  logic [DW-1:0]  alu_res;
  logic           alu_e_upd;
  logic           alu_e_val;

`ifdef BC_IO_EN
  logic [7:0] inpr_q;
  logic [7:0] outr_q;
  logic       fgi_q;
  logic       fgo_q;
`endif

  always_comb begin
    bus_w = '0;
    case (dp.bus_sel)
      3'd0: bus_w = DW'(ar_q);
      3'd1: bus_w = DW'(pc_q);
      3'd2: bus_w = dr_q;
      3'd3: bus_w = ac_q;
      3'd4: bus_w = ir_q;
      3'd5: bus_w = tr_q;
      3'd6: bus_w = mem[ar_q];
      default: bus_w = dp.ext_word;
    endcase
  end

  // Only ADD, CIR and CIL steer E; every other op leaves it to clr_e/cme.
  always_comb begin
    alu_res   = ac_q;
    alu_e_upd = 1'b0;
    alu_e_val = e_q;
    case (dp.alu_op)
      ALU_AND: alu_res = ac_q & dr_q;
      ALU_ADD: begin
        {alu_e_val, alu_res} = {1'b0, ac_q} + {1'b0, dr_q};
        alu_e_upd = 1'b1;
      end
      ALU_LDA: alu_res = dr_q;
      ALU_CMA: alu_res = ~ac_q;
      ALU_CIR: begin
        alu_res   = {e_q, ac_q[DW-1:1]};
        alu_e_val = ac_q[0];
        alu_e_upd = 1'b1;
      end
      ALU_CIL: begin
        alu_res   = {ac_q[DW-2:0], e_q};
        alu_e_val = ac_q[DW-1];
        alu_e_upd = 1'b1;
      end
`ifdef BC_IO_EN
      ALU_INP: alu_res = {ac_q[DW-1:8], inpr_q};
`endif
      default: alu_res = ac_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ar_q <= '0;
      pc_q <= '0;
      dr_q <= '0;
      ac_q <= '0;
      ir_q <= '0;
      tr_q <= '0;
      e_q  <= 1'b0;
      sc_q <= '0;
    end else begin
      if (clr_ar)      ar_q <= '0;
      else if (ld_ar)  ar_q <= AW'(bus_w);
      else if (inr_ar) ar_q <= ar_q + AW'(1);

      if (clr_pc)      pc_q <= '0;
      else if (ld_pc)  pc_q <= AW'(bus_w);
      else if (inr_pc) pc_q <= pc_q + AW'(1);

      if (clr_dr)      dr_q <= '0;
      else if (ld_dr)  dr_q <= bus_w;
      else if (inr_dr) dr_q <= dr_q + DW'(1);

      if (clr_ac)      ac_q <= '0;
      else if (ld_ac)  ac_q <= alu_res;
      else if (inr_ac) ac_q <= ac_q + DW'(1);

      if (ld_ir) ir_q <= bus_w;

      if (clr_tr)      tr_q <= '0;
      else if (ld_tr)  tr_q <= bus_w;
      else if (inr_tr) tr_q <= tr_q + DW'(1);

      if (clr_e)                    e_q <= 1'b0;
      else if (cme)                 e_q <= ~e_q;
      else if (ld_ac && alu_e_upd)  e_q <= alu_e_val;

      if (sc_clr) sc_q <= '0;
      else        sc_q <= sc_q + SCW'(1);
    end
  end

  // Memory has no reset; rst only blocks a write that is in flight.
  always_ff @(posedge clk) begin
    if (!rst && mem_we) mem[ar_q] <= bus_w;
  end

`ifdef BC_IO_EN
  // A fresh character takes priority over inp_ack when FGI is already clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      inpr_q <= '0;
      outr_q <= '0;
      fgi_q  <= 1'b0;
      fgo_q  <= 1'b1;
    end else begin
      if (dp.in_valid && !fgi_q) begin
        inpr_q <= dp.in_data;
        fgi_q  <= 1'b1;
      end else if (inp_ack) begin
        fgi_q  <= 1'b0;
      end

      if (ld_outr) begin
        outr_q <= ac_q[7:0];
        fgo_q  <= 1'b0;
      end else if (!fgo_q && dp.out_ready) begin
        fgo_q  <= 1'b1;
      end
    end
  end

  assign dp.in_ready  = ~fgi_q;
  assign dp.out_valid = ~fgo_q;
  assign dp.out_data  = outr_q;
  assign dp.fgi       = fgi_q;
  assign dp.fgo       = fgo_q;

  logic unused_bits;
  assign unused_bits = ^dp.ctrl[23:22];
`else
  assign dp.in_ready  = 1'b0;
  assign dp.out_valid = 1'b0;
  assign dp.out_data  = '0;
  assign dp.fgi       = 1'b0;
  assign dp.fgo       = 1'b1;

  logic unused_bits;
  assign unused_bits = ^{dp.ctrl[23:22], ld_outr, inp_ack, dp.in_valid, dp.in_data, dp.out_ready};
`endif

  assign dp.ar      = ar_q;
  assign dp.pc      = pc_q;
  assign dp.dr      = dr_q;
  assign dp.ac      = ac_q;
  assign dp.ir      = ir_q;
  assign dp.tr      = tr_q;
  assign dp.e       = e_q;
  assign dp.sc      = sc_q;
  assign dp.ac_zero = (ac_q == '0);

endmodule

// File: tb/tb_bc_datapath_gen.sv
// Bench for bc_datapath_gen: ALU vector table, directed multi-cycle sequences and random
// control words checked against a behavioural model. Honours BC_IO_EN like the design.
module tb_bc_datapath_gen;
  localparam int DW  = 16;
  localparam int AW  = 12;
  localparam int SCW = 4;

  localparam logic [23:0] LD_AR   = 24'h000001;
  localparam logic [23:0] LD_PC   = 24'h000008;
  localparam logic [23:0] INR_PC  = 24'h000010;
  localparam logic [23:0] CLR_PC  = 24'h000020;
  localparam logic [23:0] LD_DR   = 24'h000040;
  localparam logic [23:0] LD_AC   = 24'h000200;
  localparam logic [23:0] LD_TR   = 24'h002000;
  localparam logic [23:0] MEM_WE  = 24'h010000;
  localparam logic [23:0] CLR_E   = 24'h020000;
  localparam logic [23:0] CME     = 24'h040000;
  localparam logic [23:0] LD_OUTR = 24'h080000;
  localparam logic [23:0] INP_ACK = 24'h100000;
  localparam logic [23:0] SC_CLR  = 24'h200000;

  localparam logic [2:0] OP_AND = 3'd0, OP_ADD = 3'd1, OP_LDA = 3'd2, OP_CMA = 3'd3;
  localparam logic [2:0] OP_CIR = 3'd4, OP_CIL = 3'd5, OP_INP = 3'd6, OP_PASS = 3'd7;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bc_datapath_gen_if #(.DW(DW), .AW(AW), .SCW(SCW)) dp ();
  bc_datapath_gen #(.DW(DW), .AW(AW), .SCW(SCW)) dut (.clk(clk), .rst(rst), .dp(dp));

  int n_pass = 0;
  int n_total = 0;

  // Behavioural model state
  logic [11:0] m_ar, m_pc;
  logic [15:0] m_dr, m_ac, m_ir, m_tr;
  logic        m_e;
  logic [3:0]  m_sc;
  logic [7:0]  m_inpr, m_outr;
  logic        m_fgi, m_fgo;
  logic [15:0] m_mem [int];

  typedef struct {
    logic [15:0] ac;
    logic [15:0] dr;
    logic        e;
    logic [2:0]  op;
    logic [15:0] exp_ac;
    logic        exp_e;
  } alu_vec_t;

  alu_vec_t vecs [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic int upd(input int old, input bit clr, input bit ld, input bit inr,
                             input int ldv, input int modulus);
    if (clr) return 0;
    if (ld)  return ldv % modulus;
    if (inr) return (old + 1) % modulus;
    return old;
  endfunction

  function automatic logic [15:0] m_bus(input logic [2:0] s, input logic [15:0] ext);
    case (s)
      3'd0: return {4'h0, m_ar};
      3'd1: return {4'h0, m_pc};
      3'd2: return m_dr;
      3'd3: return m_ac;
      3'd4: return m_ir;
      3'd5: return m_tr;
      3'd6: return m_mem.exists(int'(m_ar)) ? m_mem[int'(m_ar)] : 16'h0;
      default: return ext;
    endcase
  endfunction

  task automatic model_step();
    logic [23:0] c;
    logic [15:0] b, res;
    int sum;
    bit eset, enew, ne;
    c = dp.ctrl;
    if (rst) begin
      m_ar = 0; m_pc = 0; m_dr = 0; m_ac = 0; m_ir = 0; m_tr = 0;
      m_e = 0; m_sc = 0; m_inpr = 0; m_outr = 0; m_fgi = 0; m_fgo = 1;
      return;
    end
    b = m_bus(dp.bus_sel, dp.ext_word);
    eset = 0; enew = 0; res = m_ac;
    case (dp.alu_op)
      OP_AND: res = m_ac & m_dr;
      OP_ADD: begin
        sum = int'(m_ac) + int'(m_dr);
        res = sum[15:0];
        eset = 1; enew = (sum > 65535);
      end
      OP_LDA: res = m_dr;
      OP_CMA: res = ~m_ac;
      OP_CIR: begin res = (m_ac >> 1) | (m_e ? 16'h8000 : 16'h0); eset = 1; enew = m_ac[0]; end
      OP_CIL: begin res = (m_ac << 1) | {15'h0, m_e}; eset = 1; enew = m_ac[15]; end
`ifdef BC_IO_EN
      OP_INP: res = (m_ac & 16'hFF00) | {8'h0, m_inpr};
`endif
      default: res = m_ac;
    endcase
    ne = c[17] ? 1'b0 : c[18] ? !m_e : (c[9] && eset) ? enew : m_e;
    if (c[16]) m_mem[int'(m_ar)] = b;
`ifdef BC_IO_EN
    if (dp.in_valid && !m_fgi) begin m_inpr = dp.in_data; m_fgi = 1; end
    else if (c[20]) m_fgi = 0;
    if (c[19]) begin m_outr = m_ac[7:0]; m_fgo = 0; end
    else if (!m_fgo && dp.out_ready) m_fgo = 1;
`endif
    m_ar = 12'(upd(int'(m_ar), c[2], c[0], c[1], int'(b[11:0]), 4096));
    m_pc = 12'(upd(int'(m_pc), c[5], c[3], c[4], int'(b[11:0]), 4096));
    m_dr = 16'(upd(int'(m_dr), c[8], c[6], c[7], int'(b), 65536));
    m_ac = 16'(upd(int'(m_ac), c[11], c[9], c[10], int'(res), 65536));
    m_ir = 16'(upd(int'(m_ir), 1'b0, c[12], 1'b0, int'(b), 65536));
    m_tr = 16'(upd(int'(m_tr), c[15], c[13], c[14], int'(b), 65536));
    m_e  = ne;
    m_sc = c[21] ? 4'h0 : 4'((int'(m_sc) + 1) % 16);
  endtask

  task automatic compare_all();
    check("ar", 32'(dp.ar), 32'(m_ar));
    check("pc", 32'(dp.pc), 32'(m_pc));
    check("dr", 32'(dp.dr), 32'(m_dr));
    check("ac", 32'(dp.ac), 32'(m_ac));
    check("ir", 32'(dp.ir), 32'(m_ir));
    check("tr", 32'(dp.tr), 32'(m_tr));
    check("e", 32'(dp.e), 32'(m_e));
    check("sc", 32'(dp.sc), 32'(m_sc));
    check("ac_zero", 32'(dp.ac_zero), 32'(m_ac == 16'h0));
`ifdef BC_IO_EN
    check("fgi", 32'(dp.fgi), 32'(m_fgi));
    check("fgo", 32'(dp.fgo), 32'(m_fgo));
    check("in_ready", 32'(dp.in_ready), 32'(!m_fgi));
    check("out_valid", 32'(dp.out_valid), 32'(!m_fgo));
    check("out_data", 32'(dp.out_data), 32'(m_outr));
`else
    check("fgi", 32'(dp.fgi), 32'h0);
    check("fgo", 32'(dp.fgo), 32'h1);
    check("in_ready", 32'(dp.in_ready), 32'h0);
    check("out_valid", 32'(dp.out_valid), 32'h0);
    check("out_data", 32'(dp.out_data), 32'h0);
`endif
  endtask

  // Inputs are applied at the falling edge; results are compared at the next falling edge.
  task automatic go(input logic [23:0] c, input logic [2:0] s, input logic [2:0] op,
                    input logic [15:0] ext);
    dp.ctrl = c; dp.bus_sel = s; dp.alu_op = op; dp.ext_word = ext;
    model_step();
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) go(24'h0, 3'd0, OP_PASS, 16'h0);
  endtask

  task automatic load_dr(input logic [15:0] v);
    go(LD_DR, 3'd7, OP_PASS, v);
  endtask

  task automatic load_ac(input logic [15:0] v);
    load_dr(v);
    go(LD_AC, 3'd0, OP_LDA, 16'h0);
  endtask

  initial begin
    logic [23:0] rc;
    logic [2:0]  rs;
    logic [15:0] rext;

    vecs[0]  = '{16'hF0F0, 16'h3C3C, 1'b0, OP_AND,  16'h3030, 1'b0};
    vecs[1]  = '{16'hFFFF, 16'h0001, 1'b0, OP_ADD,  16'h0000, 1'b1};
    vecs[2]  = '{16'h1234, 16'h0100, 1'b1, OP_ADD,  16'h1334, 1'b0};
    vecs[3]  = '{16'h0000, 16'hABCD, 1'b1, OP_LDA,  16'hABCD, 1'b1};
    vecs[4]  = '{16'h00FF, 16'h1111, 1'b0, OP_CMA,  16'hFF00, 1'b0};
    vecs[5]  = '{16'h0001, 16'h0000, 1'b0, OP_CIR,  16'h0000, 1'b1};
    vecs[6]  = '{16'h0000, 16'h0000, 1'b1, OP_CIR,  16'h8000, 1'b0};
    vecs[7]  = '{16'h8000, 16'h0000, 1'b0, OP_CIL,  16'h0000, 1'b1};
    vecs[8]  = '{16'h4001, 16'h0000, 1'b1, OP_CIL,  16'h8003, 1'b0};
    vecs[9]  = '{16'h5A5A, 16'h0F0F, 1'b1, OP_PASS, 16'h5A5A, 1'b1};
    vecs[10] = '{16'h8000, 16'h8000, 1'b0, OP_ADD,  16'h0000, 1'b1};
`ifdef BC_IO_EN
    vecs[11] = '{16'h1234, 16'h0000, 1'b0, OP_INP,  16'h1200, 1'b0};
`else
    vecs[11] = '{16'h1234, 16'h0000, 1'b0, OP_INP,  16'h1234, 1'b0};
`endif

    dp.in_valid = 0; dp.in_data = 0; dp.out_ready = 0;
    rst = 1;
    go(24'h0, 3'd0, OP_PASS, 16'h0);
    rst = 0;
    check("reset_ac_zero", 32'(dp.ac_zero), 32'h1);
    check("reset_fgo", 32'(dp.fgo), 32'h1);
    check("reset_sc", 32'(dp.sc), 32'h0);

    idle(16);
    check("sc_wrap", 32'(dp.sc), 32'h0);
    idle(3);
    check("sc_after_wrap", 32'(dp.sc), 32'h3);
    idle(2);
    check("sc_at_5", 32'(dp.sc), 32'h5);
    go(SC_CLR, 3'd0, OP_PASS, 16'h0);
    check("sc_clr", 32'(dp.sc), 32'h0);

    for (int i = 0; i < 12; i++) begin
      load_ac(vecs[i].ac);
      load_dr(vecs[i].dr);
      go(CLR_E, 3'd0, OP_PASS, 16'h0);
      if (vecs[i].e) go(CME, 3'd0, OP_PASS, 16'h0);
      go(LD_AC, 3'd0, vecs[i].op, 16'h0);
      check($sformatf("alu_vec%0d_ac", i), 32'(dp.ac), 32'(vecs[i].exp_ac));
      check($sformatf("alu_vec%0d_e", i), 32'(dp.e), 32'(vecs[i].exp_e));
    end

    go(LD_AR | LD_DR, 3'd7, OP_PASS, 16'h1234);
    check("ar_ext", 32'(dp.ar), 32'h234);
    check("dr_ext", 32'(dp.dr), 32'h1234);
    go(MEM_WE, 3'd7, OP_PASS, 16'h1234);
    go(LD_TR, 3'd6, OP_PASS, 16'h0);
    check("mem_readback", 32'(dp.tr), 32'h1234);
    go(LD_DR, 3'd2, OP_PASS, 16'h0);
    check("dr_self_load", 32'(dp.dr), 32'h1234);

    load_ac(16'hFFFF);
    load_dr(16'h0001);
    go(CLR_E, 3'd0, OP_PASS, 16'h0);
    go(LD_AC, 3'd0, OP_ADD, 16'h0);
    check("add_ac", 32'(dp.ac), 32'h0);
    check("add_e", 32'(dp.e), 32'h1);
    check("add_zero", 32'(dp.ac_zero), 32'h1);
    go(LD_AC, 3'd0, OP_CIR, 16'h0);
    check("cir_ac", 32'(dp.ac), 32'h8000);
    check("cir_e", 32'(dp.e), 32'h0);

    go(LD_PC | INR_PC, 3'd7, OP_PASS, 16'h0ABC);
    check("pc_ld_over_inr", 32'(dp.pc), 32'hABC);
    go(CLR_PC | LD_PC, 3'd7, OP_PASS, 16'h0123);
    check("pc_clr_over_ld", 32'(dp.pc), 32'h0);
    go(LD_PC, 3'd7, OP_PASS, 16'h0FFF);
    go(INR_PC, 3'd0, OP_PASS, 16'h0);
    check("pc_wrap", 32'(dp.pc), 32'h0);

    // Reset during a write must leave the memory word untouched.
    go(LD_AR, 3'd7, OP_PASS, 16'h0234);
    rst = 1;
    go(MEM_WE, 3'd7, OP_PASS, 16'hBEEF);
    rst = 0;
    check("rst_ar", 32'(dp.ar), 32'h0);
    go(LD_AR, 3'd7, OP_PASS, 16'h0234);
    go(LD_TR, 3'd6, OP_PASS, 16'h0);
    check("rst_blocks_we", 32'(dp.tr), 32'h1234);

`ifdef BC_IO_EN
    dp.in_valid = 1; dp.in_data = 8'h41;
    go(24'h0, 3'd0, OP_PASS, 16'h0);
    check("in_fgi_set", 32'(dp.fgi), 32'h1);
    check("in_ready_low", 32'(dp.in_ready), 32'h0);
    dp.in_data = 8'h42;
    go(24'h0, 3'd0, OP_PASS, 16'h0);
    go(LD_AC | INP_ACK, 3'd0, OP_INP, 16'h0);
    dp.in_valid = 0;
    check("inp_char", 32'(dp.ac[7:0]), 32'h41);
    check("inp_ack_fgi", 32'(dp.fgi), 32'h0);

    load_ac(16'h0055);
    go(LD_OUTR, 3'd0, OP_PASS, 16'h0);
    check("out_valid_set", 32'(dp.out_valid), 32'h1);
    check("out_data", 32'(dp.out_data), 32'h55);
    for (int i = 0; i < 3; i++) begin
      go(24'h0, 3'd0, OP_PASS, 16'h0);
      check("out_valid_hold", 32'(dp.out_valid), 32'h1);
    end
    dp.out_ready = 1;
    go(24'h0, 3'd0, OP_PASS, 16'h0);
    check("out_accept_fgo", 32'(dp.fgo), 32'h1);
    dp.out_ready = 0;
    load_ac(16'h00AA);
    go(LD_OUTR, 3'd0, OP_PASS, 16'h0);
    load_ac(16'h00C3);
    dp.out_ready = 1;
    go(LD_OUTR, 3'd0, OP_PASS, 16'h0);
    dp.out_ready = 0;
    check("outr_wins_fgo", 32'(dp.fgo), 32'h0);
    check("outr_wins_data", 32'(dp.out_data), 32'hC3);
`else
    load_ac(16'h0055);
    dp.in_valid = 1; dp.in_data = 8'h41; dp.out_ready = 1;
    go(LD_OUTR | INP_ACK, 3'd0, OP_PASS, 16'h0);
    check("noio_out_valid", 32'(dp.out_valid), 32'h0);
    check("noio_in_ready", 32'(dp.in_ready), 32'h0);
    go(LD_AC, 3'd0, OP_INP, 16'h0);
    check("noio_inp_pass", 32'(dp.ac), 32'h0055);
    dp.in_valid = 0; dp.out_ready = 0;
`endif

    for (int i = 0; i < 400; i++) begin
      rc = 24'h0;
      for (int j = 0; j < 24; j++) if ($urandom_range(0, 5) == 0) rc[j] = 1'b1;
      rs = 3'($urandom_range(0, 7));
      if (rs == 3'd6 && !m_mem.exists(int'(m_ar))) rs = 3'd7;
      rext = 16'($urandom);
      if ($urandom_range(0, 1) == 1) rext[11:0] = 12'($urandom_range(0, 15));
      dp.in_valid  = 1'($urandom_range(0, 1));
      dp.in_data   = 8'($urandom);
      dp.out_ready = 1'($urandom_range(0, 1));
      go(rc, rs, 3'($urandom_range(0, 7)), rext);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
